// File: rtl/visor_observe_sequencer.sv
// Breakpoint "observe register" sequencer: holds the target, injects
// `r15 = rN`, captures the result, restores exr, releases the breakpoint once,
// then posts the captured value to the JTAG UART over an Avalon write.
//
// Avalon handshake: a write is offered while av_write=1. It is accepted on the
// first cycle av_waitrequest=0. Address and data stay stable while stalled. If
// the slave stalls for TIMEOUT counted cycles, the write is withdrawn
// (av_write=0) and the sample is marked dropped.
module visor_observe_sequencer #(
    parameter int              AW        = 8,
    parameter logic [AW-1:0]   UART_ADDR = '0,
    parameter logic [15:0]     OPC_BASE  = 16'h3c00,
    parameter int              TIMEOUT   = 1023
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          enable,
    input  logic          bp_hit,
    input  logic [3:0]    reg_sel,
    input  logic [15:0]   exr_shadow,
    input  logic [15:0]   tg_to_visor,
    input  logic          av_waitrequest,
    output logic          divert_code_bus,
    output logic [15:0]   tg_code_in,
    output logic [2:0]    tg_force,
    output logic          bp_release,
    output logic [AW-1:0] av_address,
    output logic          av_write,
    output logic [15:0]   av_writedata,
    output logic [15:0]   sample,
    output logic          sample_valid,
    output logic          busy,
    output logic          dropped,
    output logic [2:0]    dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE, S_DIVERT, S_LOAD, S_EXEC, S_CAPTURE, S_RESTORE, S_RELEASE, S_AVWR
    } state_e;

    localparam int            CW     = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TO_MAX = CW'(TIMEOUT);

    state_e        state_q, state_d;
    logic          bp_prev_q, bp_prev_d;
    logic [3:0]    reg_sel_q, reg_sel_d;
    logic [15:0]   sample_q, sample_d;
    logic          dropped_q, dropped_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [15:0]   inj_word;

    assign inj_word  = OPC_BASE | {12'h000, reg_sel_q};
    assign sample    = sample_q;
    assign dropped   = dropped_q;
    assign busy      = (state_q != S_IDLE);
    assign dbg_state = state_q;

    // State and datapath registers; edge register resets high so a bp_hit
    // already asserted at reset release is not mistaken for a new hit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            bp_prev_q <= 1'b1;
            reg_sel_q <= '0;
            sample_q  <= '0;
            dropped_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            bp_prev_q <= bp_prev_d;
            reg_sel_q <= reg_sel_d;
            sample_q  <= sample_d;
            dropped_q <= dropped_d;
            cnt_q     <= cnt_d;
        end
    end

    // Next-state and Moore/handshake outputs; everything defaults to idle.
    always_comb begin
        state_d         = state_q;
        bp_prev_d       = bp_prev_q;
        reg_sel_d       = reg_sel_q;
        sample_d        = sample_q;
        dropped_d       = dropped_q;
        cnt_d           = cnt_q;
        divert_code_bus = 1'b0;
        tg_code_in      = '0;
        tg_force        = 3'b000;
        bp_release      = 1'b0;
        av_address      = '0;
        av_write        = 1'b0;
        av_writedata    = '0;
        sample_valid    = 1'b0;

        case (state_q)
            S_IDLE: begin
                // Edge history only advances in IDLE, so toggles while busy
                // cannot arm a trigger; bp_hit must drop low in IDLE first.
                bp_prev_d = bp_hit;
                cnt_d     = '0;
                if (enable && bp_hit && !bp_prev_q) begin
                    reg_sel_d = reg_sel;
                    dropped_d = 1'b0;
                    state_d   = S_DIVERT;
                end
            end
            S_DIVERT: begin
                divert_code_bus = 1'b1;
                tg_code_in      = inj_word;
                tg_force        = 3'b001;
                state_d         = S_LOAD;
            end
            S_LOAD: begin
                divert_code_bus = 1'b1;
                tg_code_in      = inj_word;
                tg_force        = 3'b011;
                state_d         = S_EXEC;
            end
            S_EXEC: begin
                divert_code_bus = 1'b1;
                tg_code_in      = inj_word;
                tg_force        = 3'b101;
                state_d         = S_CAPTURE;
            end
            S_CAPTURE: begin
                divert_code_bus = 1'b1;
                tg_code_in      = inj_word;
                tg_force        = 3'b001;
                sample_d        = tg_to_visor;
                state_d         = S_RESTORE;
            end
            S_RESTORE: begin
                // exr_shadow is taken live here, not latched at trigger.
                divert_code_bus = 1'b1;
                tg_code_in      = exr_shadow;
                tg_force        = 3'b011;
                state_d         = S_RELEASE;
            end
            S_RELEASE: begin
                bp_release = 1'b1;
                state_d    = S_AVWR;
            end
            S_AVWR: begin
                av_address   = UART_ADDR;
                av_writedata = sample_q;
                if (!av_waitrequest) begin
                    av_write     = 1'b1;
                    sample_valid = 1'b1;
                    state_d      = S_IDLE;
                end else if (cnt_q == TO_MAX) begin
                    dropped_d    = 1'b1;
                    sample_valid = 1'b1;
                    state_d      = S_IDLE;
                end else begin
                    av_write = 1'b1;
                    cnt_d    = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_visor_observe_sequencer.sv
// Directed bench for visor_observe_sequencer: reset values, basic sequence,
// slave stall, timeout/drop, retrigger rules, reset mid-EXEC, register sweep.
module tb_visor_observe_sequencer;

    localparam int         AW = 8;
    localparam logic [7:0] UA = 8'h2c;
    localparam int         TO = 4;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          enable = 1'b1;
    logic          bp_hit = 1'b1;
    logic [3:0]    reg_sel = '0;
    logic [15:0]   exr_shadow = '0;
    logic [15:0]   tg_to_visor = '0;
    logic          av_waitrequest = 1'b0;
    logic          divert_code_bus;
    logic [15:0]   tg_code_in;
    logic [2:0]    tg_force;
    logic          bp_release;
    logic [AW-1:0] av_address;
    logic          av_write;
    logic [15:0]   av_writedata;
    logic [15:0]   sample;
    logic          sample_valid;
    logic          busy;
    logic          dropped;
    logic [2:0]    dbg_state;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    visor_observe_sequencer #(
        .AW(AW), .UART_ADDR(UA), .OPC_BASE(16'h3c00), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .bp_hit(bp_hit),
        .reg_sel(reg_sel), .exr_shadow(exr_shadow), .tg_to_visor(tg_to_visor),
        .av_waitrequest(av_waitrequest), .divert_code_bus(divert_code_bus),
        .tg_code_in(tg_code_in), .tg_force(tg_force), .bp_release(bp_release),
        .av_address(av_address), .av_write(av_write), .av_writedata(av_writedata),
        .sample(sample), .sample_valid(sample_valid), .busy(busy),
        .dropped(dropped), .dbg_state(dbg_state)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are read at the falling edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    // mode 0: bp_hit dropped after the sequence; 1: held high throughout;
    // 2: toggled while busy. stalls >= TO means the slave never accepts.
    task automatic run_seq(input logic [3:0] rs, input logic [15:0] val,
                           input logic [15:0] exr, input int stalls, input int mode);
        bit          timeout = (stalls >= TO);
        int          last    = (stalls >= TO) ? TO : stalls;
        logic [15:0] inj     = 16'h3c00 | {12'h000, rs};
        logic [2:0]  fexp [6] = '{3'd1, 3'd3, 3'd5, 3'd1, 3'd3, 3'd0};
        logic [15:0] cexp;
        bit          wexp;
        // Cycle T: IDLE sees the rising edge
        tick();
        enable = 1'b1; bp_hit = 1'b1; reg_sel = rs;
        tg_to_visor = ~val; exr_shadow = ~exr; av_waitrequest = 1'b0;
        mid();
        chk("trig_busy", 32'(busy), 0);
        // T+1..T+6: DIVERT .. RELEASE
        for (int k = 1; k <= 6; k++) begin
            tick();
            reg_sel     = ~rs;
            tg_to_visor = (k == 4) ? val : ~val;
            exr_shadow  = (k == 5) ? exr : ~exr;
            if (mode == 2) bp_hit = k[0];
            mid();
            cexp = (k <= 4) ? inj : ((k == 5) ? exr : 16'h0000);
            chk("force", 32'(tg_force), 32'(fexp[k-1]));
            chk("code", 32'(tg_code_in), 32'(cexp));
            chk("divert", 32'(divert_code_bus), 32'(k <= 5));
            chk("bp_release", 32'(bp_release), 32'(k == 6));
            chk("busy_seq", 32'(busy), 1);
            if (k == 1) chk("dropped_cleared", 32'(dropped), 0);
        end
        // T+7..: AVWR
        for (int s = 0; s <= last; s++) begin
            tick();
            av_waitrequest = timeout ? 1'b1 : (s < stalls);
            if (mode == 2) bp_hit = ~s[0];
            mid();
            wexp = !(timeout && s == TO);
            chk("av_write", 32'(av_write), 32'(wexp));
            if (wexp) begin
                chk("av_address", 32'(av_address), 32'(UA));
                chk("av_writedata", 32'(av_writedata), 32'(val));
            end
            chk("sample_valid", 32'(sample_valid), 32'(s == last));
            chk("busy_avwr", 32'(busy), 1);
            chk("sample", 32'(sample), 32'(val));
        end
        tick();
        av_waitrequest = 1'b0;
        bp_hit = (mode == 0) ? 1'b0 : 1'b1;
        mid();
        chk("done_busy", 32'(busy), 0);
        chk("done_write", 32'(av_write), 0);
        chk("done_valid", 32'(sample_valid), 0);
        chk("dropped", 32'(dropped), 32'(timeout));
        chk("done_sample", 32'(sample), 32'(val));
        if (mode != 0) begin
            for (int i = 0; i < 3; i++) begin
                tick();
                bp_hit = 1'b1;
                mid();
                chk("no_retrigger", 32'(busy), 0);
            end
            tick();
            bp_hit = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        #2;
        chk("rst_force", 32'(tg_force), 0);
        chk("rst_divert", 32'(divert_code_bus), 0);
        chk("rst_code", 32'(tg_code_in), 0);
        chk("rst_av_write", 32'(av_write), 0);
        chk("rst_bp_release", 32'(bp_release), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_sample", 32'(sample), 0);
        chk("rst_valid", 32'(sample_valid), 0);
        chk("rst_dropped", 32'(dropped), 0);
        chk("rst_state", 32'(dbg_state), 0);
        tick(); tick();
        reset_n = 1'b1;
        // bp_hit already high at reset release must not trigger
        for (int i = 0; i < 3; i++) begin
            tick();
            mid();
            chk("no_trig_after_reset", 32'(busy), 0);
        end
        tick();
        bp_hit = 1'b0;
        mid();

        // Basic sequence, zero-wait write
        run_seq(4'd7, 16'h1234, 16'hbeef, 0, 0);
        // Slave stall of 3 cycles
        run_seq(4'd2, 16'ha5c3, 16'h0f0f, 3, 0);
        // Timeout: slave never accepts
        run_seq(4'd5, 16'h7e81, 16'h1357, TO, 0);
        // Next trigger clears dropped; bp_hit held high afterwards
        run_seq(4'd3, 16'h0bad, 16'h2468, 0, 1);
        // bp_hit toggled while busy
        run_seq(4'd12, 16'hc0de, 16'h9999, 1, 2);

        // Edge with enable low: no action
        tick();
        enable = 1'b0; bp_hit = 1'b1;
        mid();
        tick();
        mid();
        chk("disabled_busy", 32'(busy), 0);
        tick();
        mid();
        chk("disabled_busy2", 32'(busy), 0);
        tick();
        bp_hit = 1'b0; enable = 1'b1;
        mid();

        // Reset mid-EXEC
        tick();
        bp_hit = 1'b1; reg_sel = 4'h9; tg_to_visor = 16'h5555;
        tick(); tick(); tick();
        mid();
        chk("exec_force", 32'(tg_force), 5);
        #1 reset_n = 1'b0;
        #1;
        chk("rst_exec_force", 32'(tg_force), 0);
        chk("rst_exec_divert", 32'(divert_code_bus), 0);
        chk("rst_exec_code", 32'(tg_code_in), 0);
        chk("rst_exec_busy", 32'(busy), 0);
        tick(); tick();
        reset_n = 1'b1;
        mid();
        chk("post_rst_busy", 32'(busy), 0);
        chk("post_rst_sample", 32'(sample), 0);
        tick();
        bp_hit = 1'b0;
        mid();
        chk("post_rst_idle", 32'(busy), 0);

        // Register sweep
        for (int r = 0; r < 16; r++) begin
            run_seq(4'(r), 16'(r * 16'h0101), 16'(16'h1000 + r), 0, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
